// File: rtl/dmem_responder_if.sv
// dmem_responder_if: request/response handshake bundle between a load/store stage and the data memory.
interface dmem_responder_if #(
  parameter int DW = 32
);
  logic          ireq_valid;
  logic          oreq_ready;
  logic          ireq_wen;
  logic [1:0]    ireq_size;
  logic [31:0]   ireq_addr;
  logic [DW-1:0] ireq_wdata;
  logic          orsp_valid;
  logic          irsp_ready;
  logic [DW-1:0] ordata;
  logic          orsp_err;
  modport slave (
    input  ireq_valid, ireq_wen, ireq_size, ireq_addr, ireq_wdata, irsp_ready,
    output oreq_ready, orsp_valid, ordata, orsp_err
  );
  modport master (
    output ireq_valid, ireq_wen, ireq_size, ireq_addr, ireq_wdata, irsp_ready,
    input  oreq_ready, orsp_valid, ordata, orsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: wait-state data-memory slave with byte/half/word lanes and a held response channel.
// Optional misalignment error reporting is enabled by defining DMEM_RESP_MISALIGN_ERR_EN.
module dmem_responder #(
  parameter int MP_DATA_WIDTH = 32,
  parameter int MP_DEPTH      = 256,
  parameter int MP_WAIT       = 2
) (
  input logic iclk,
  input logic irst,
  dmem_responder_if.slave bus
);
  localparam int AW = $clog2(MP_DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  state_e                   state_q;
  logic [3:0]               cnt_q;
  logic                     wen_q;
  logic [1:0]               size_q;
  logic [AW+1:0]            addr_q;
  logic [MP_DATA_WIDTH-1:0] wdata_q;
  logic                     ready_q, rsp_valid_q, err_q;
  logic [MP_DATA_WIDTH-1:0] rdata_q;
  logic [MP_DATA_WIDTH-1:0] mem [MP_DEPTH];
  logic                     live, commit, c_wen, mis;
  logic [1:0]               c_size, off;
  logic [AW+1:0]            c_addr;
  logic [AW-1:0]            idx;
  logic [3:0]               be;
  logic [MP_DATA_WIDTH-1:0] c_wdata, wd, word, shifted, ld_d;
  logic                     unused_addr;
  // With zero wait states the commit happens on the accept edge, so it must use the live request.
  assign live    = state_q == IDLE;
  assign c_wen   = live ? bus.ireq_wen : wen_q;
  assign c_size  = live ? bus.ireq_size : size_q;
  assign c_addr  = live ? bus.ireq_addr[AW+1:0] : addr_q;
  assign c_wdata = live ? bus.ireq_wdata : wdata_q;
  assign commit  = (live && bus.ireq_valid && MP_WAIT == 0) || (state_q == WAIT && cnt_q == 4'd0);
  assign unused_addr = ^bus.ireq_addr[31:AW+2];
`ifdef DMEM_RESP_MISALIGN_ERR_EN
  assign mis = c_size[1] ? (c_addr[1:0] != 2'b00) : (c_size[0] & c_addr[0]);
  assign off = c_addr[1:0];
`else
  assign mis = 1'b0;
  assign off = c_size[1] ? 2'b00 : c_size[0] ? {c_addr[1], 1'b0} : c_addr[1:0];
`endif
  assign idx     = c_addr[AW+1:2];
  assign be      = c_size[1] ? 4'hf : c_size[0] ? 4'b0011 << off : 4'b0001 << off;
  assign wd      = c_wdata << {off, 3'b000};
  assign word    = mem[idx];
  assign shifted = word >> {off, 3'b000};
  assign ld_d    = (c_wen || mis) ? '0 : c_size[1] ? word :
                   c_size[0] ? {16'b0, shifted[15:0]} : {24'b0, shifted[7:0]};
  always_ff @(posedge iclk)
    if (!irst && commit && c_wen && !mis)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
  always_ff @(posedge iclk)
    if (irst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      if (live && bus.ireq_valid) begin
        wen_q   <= bus.ireq_wen;
        size_q  <= bus.ireq_size;
        addr_q  <= bus.ireq_addr[AW+1:0];
        wdata_q <= bus.ireq_wdata;
        ready_q <= 1'b0;
        state_q <= WAIT;
        cnt_q   <= 4'(MP_WAIT - 1);
      end
      if (state_q == WAIT) cnt_q <= cnt_q - 4'd1;
      if (commit) begin
        state_q     <= RESP;
        rsp_valid_q <= 1'b1;
        rdata_q     <= ld_d;
        err_q       <= mis;
      end
      if (state_q == RESP && bus.irsp_ready) begin
        state_q     <= IDLE;
        rsp_valid_q <= 1'b0;
        ready_q     <= 1'b1;
      end
    end
  assign bus.oreq_ready = ready_q;
  assign bus.orsp_valid = rsp_valid_q;
  assign bus.ordata     = rdata_q;
  assign bus.orsp_err   = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed vector table plus hand sequences for backpressure and reset-in-flight.
module tb_dmem_responder;
  localparam int WAITS = 2;
  logic iclk = 1'b0;
  logic irst = 1'b1;
  always #5 iclk = ~iclk;
  dmem_responder_if bus ();
  dmem_responder #(.MP_DATA_WIDTH(32), .MP_DEPTH(256), .MP_WAIT(WAITS)) dut (
    .iclk(iclk), .irst(irst), .bus(bus)
  );
  int checks = 0;
  int fails  = 0;
  typedef struct {
    logic        wen;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;
  vec_t tbl [13];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input logic wen, input logic [1:0] size, input logic [31:0] addr,
                       input logic [31:0] wdata);
    bus.ireq_valid = 1'b1;
    bus.ireq_wen   = wen;
    bus.ireq_size  = size;
    bus.ireq_addr  = addr;
    bus.ireq_wdata = wdata;
  endtask
  task automatic scramble();
    bus.ireq_valid = 1'b0;
    bus.ireq_wen   = 1'b1;
    bus.ireq_size  = 2'b00;
    bus.ireq_addr  = 32'hffff_fffd;
    bus.ireq_wdata = 32'h5a5a_5a5a;
  endtask
  task automatic txn(input logic wen, input logic [1:0] size, input logic [31:0] addr,
                     input logic [31:0] wdata, output logic [31:0] rdata, output logic err,
                     output int lat);
    int n = 0;
    while (!bus.oreq_ready && n < 50) begin @(posedge iclk); #1; n++; end
    drive(wen, size, addr, wdata);
    @(posedge iclk); #1;
    scramble();
    lat = 1;
    while (!bus.orsp_valid && lat < 50) begin @(posedge iclk); #1; lat++; end
    rdata = bus.ordata;
    err   = bus.orsp_err;
    if (bus.irsp_ready) begin @(posedge iclk); #1; end
  endtask
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    logic [31:0] rd, hold;
    logic        er;
    int          lat, n;
    tbl[0]  = '{1'b1, 2'b10, 32'h10,  32'hdeadbeef, 32'h0,        1'b0};
    tbl[1]  = '{1'b0, 2'b10, 32'h10,  32'h0,        32'hdeadbeef, 1'b0};
    tbl[2]  = '{1'b1, 2'b00, 32'h13,  32'h000000aa, 32'h0,        1'b0};
    tbl[3]  = '{1'b1, 2'b01, 32'h10,  32'h00001234, 32'h0,        1'b0};
    tbl[4]  = '{1'b0, 2'b10, 32'h10,  32'h0,        32'haaad1234, 1'b0};
    tbl[5]  = '{1'b0, 2'b00, 32'h13,  32'h0,        32'h000000aa, 1'b0};
    tbl[6]  = '{1'b0, 2'b01, 32'h12,  32'h0,        32'h0000aaad, 1'b0};
    tbl[7]  = '{1'b0, 2'b00, 32'h11,  32'hffffffff, 32'h00000012, 1'b0};
    tbl[8]  = '{1'b1, 2'b10, 32'h400, 32'h00000055, 32'h0,        1'b0};
    tbl[9]  = '{1'b0, 2'b10, 32'h0,   32'h0,        32'h00000055, 1'b0};
    tbl[10] = '{1'b1, 2'b10, 32'h20,  32'h01020304, 32'h0,        1'b0};
    tbl[11] = '{1'b0, 2'b11, 32'h20,  32'h0,        32'h01020304, 1'b0};
    tbl[12] = '{1'b0, 2'b01, 32'h22,  32'h0,        32'h00000102, 1'b0};
    scramble();
    bus.irsp_ready = 1'b1;
    irst = 1'b1;
    repeat (2) @(posedge iclk);
    #1 irst = 1'b0;
    chk("reset_ready", 32'(bus.oreq_ready), 32'd1);
    chk("reset_valid", 32'(bus.orsp_valid), 32'd0);
    chk("reset_rdata", bus.ordata, 32'h0);
    chk("reset_err", 32'(bus.orsp_err), 32'd0);
    for (int i = 0; i < 13; i++) begin
      txn(tbl[i].wen, tbl[i].size, tbl[i].addr, tbl[i].wdata, rd, er, lat);
      chk($sformatf("vec%0d_rdata", i), rd, tbl[i].rdata);
      chk($sformatf("vec%0d_err", i), 32'(er), 32'(tbl[i].err));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(WAITS + 1));
    end
    // Backpressure: response held while a second request waits.
    bus.irsp_ready = 1'b0;
    drive(1'b0, 2'b10, 32'h10, 32'h0);
    @(posedge iclk); #1;
    drive(1'b0, 2'b00, 32'h13, 32'h0);
    n = 0;
    while (!bus.orsp_valid && n < 50) begin @(posedge iclk); #1; n++; end
    hold = bus.ordata;
    chk("bp_rdata", hold, 32'haaad1234);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp_valid_c%0d", c), 32'(bus.orsp_valid), 32'd1);
      chk($sformatf("bp_ready_c%0d", c), 32'(bus.oreq_ready), 32'd0);
      chk($sformatf("bp_hold_c%0d", c), bus.ordata, hold);
      @(posedge iclk); #1;
    end
    bus.irsp_ready = 1'b1;
    @(posedge iclk); #1;
    chk("bp_after_hs_valid", 32'(bus.orsp_valid), 32'd0);
    chk("bp_after_hs_ready", 32'(bus.oreq_ready), 32'd1);
    @(posedge iclk); #1;
    chk("bp_accept_next", 32'(bus.oreq_ready), 32'd0);
    scramble();
    n = 0;
    while (!bus.orsp_valid && n < 50) begin @(posedge iclk); #1; n++; end
    chk("bp_second_rdata", bus.ordata, 32'h000000aa);
    chk("bp_second_wait", 32'(n), 32'(WAITS));
    @(posedge iclk); #1;
    // Reset lands on the edge that would have committed the store.
    drive(1'b1, 2'b10, 32'h20, 32'hffffffff);
    @(posedge iclk); #1;
    scramble();
    irst = 1'b1;
    repeat (2) @(posedge iclk);
    #1 irst = 1'b0;
    chk("rst_mid_ready", 32'(bus.oreq_ready), 32'd1);
    chk("rst_mid_valid", 32'(bus.orsp_valid), 32'd0);
    txn(1'b0, 2'b10, 32'h20, 32'h0, rd, er, lat);
    chk("rst_mid_mem", rd, 32'h01020304);
    txn(1'b1, 2'b10, 32'h22, 32'h11223344, rd, er, lat);
    chk("mis_store_rdata", rd, 32'h0);
`ifdef DMEM_RESP_MISALIGN_ERR_EN
    chk("mis_store_err", 32'(er), 32'd1);
    txn(1'b0, 2'b10, 32'h20, 32'h0, rd, er, lat);
    chk("mis_mem", rd, 32'h01020304);
    chk("mis_aligned_err", 32'(er), 32'd0);
    txn(1'b0, 2'b01, 32'h11, 32'h0, rd, er, lat);
    chk("mis_half_rdata", rd, 32'h0);
    chk("mis_half_err", 32'(er), 32'd1);
`else
    chk("mis_store_err", 32'(er), 32'd0);
    txn(1'b0, 2'b10, 32'h20, 32'h0, rd, er, lat);
    chk("mis_mem", rd, 32'h11223344);
    chk("mis_aligned_err", 32'(er), 32'd0);
    txn(1'b0, 2'b01, 32'h11, 32'h0, rd, er, lat);
    chk("mis_half_rdata", rd, 32'h00001234);
    chk("mis_half_err", 32'(er), 32'd0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
